quick_spi_master: RTL and testbench
===================================

Name:
quick_spi_master

Overview:
- Single-clock SPI master for byte-oriented peripherals.
- Supports two operations:
  - Write: shifts a 16-bit word out on mosi.
  - Read: shifts an 8-bit command out on mosi, then shifts an 8-bit response in from miso.
- Generates sclk as clk/2 and drives one active-low slave select per slave.
- Sits between a register/control FSM and off-chip SPI devices; signals completion with a one-cycle end_of_transaction pulse.

Parameters:
- NUM_SLAVES, 2, number of ss_n lines (width of ss_n).
- SLAVE_ID_W, 2, width of slave index input.
- OUT_W, 16, bits shifted in a write operation.
- CMD_W, 8, command bits shifted before reading; taken from outgoing_data[OUT_W-1 -: CMD_W].
- IN_W, 8, bits captured in a read operation.
- CPOL, 0, sclk idle level.
- CPHA, 0, sampling phase:
  - 0: sample on the leading sclk edge, shift on the trailing edge.
  - 1: shift on the leading edge, sample on the trailing edge.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; gates acceptance of new transactions only.
- start_transaction  in  1  level request; sampled in IDLE.
- slave  in  SLAVE_ID_W  index of target slave.
- operation  in  1  0 = write, 1 = read.
- outgoing_data  in  OUT_W  transmit word, MSB first.
- miso  in  1  serial data from slave.
- end_of_transaction  out  1  one-clk pulse at transaction completion.
- incoming_data  out  IN_W  last received byte.
- mosi  out  1  serial data to slave.
- sclk  out  1  SPI clock.
- ss_n  out  NUM_SLAVES  one-cold slave selects.

Behaviour:
- Reset (async, active-low):
  - State IDLE; sclk=CPOL, mosi=0, ss_n all 1, end_of_transaction=0, incoming_data=0.
  - Reset asserted mid-transaction aborts immediately to these values.
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, SETUP, SHIFT, DONE.
- IDLE:
  - If enable && start_transaction && slave<NUM_SLAVES: latch outgoing_data, operation and slave; go to SETUP.
  - Otherwise stay in IDLE. An out-of-range slave index is ignored.
- SETUP (1 clk):
  - ss_n[slave]=0, all other ss_n bits stay 1.
  - Present the first bit: mosi=latched MSB (CPHA=0) or mosi unchanged (CPHA=1).
  - sclk stays CPOL.
- SHIFT:
  - sclk toggles every clk cycle.
  - Total edges: 2*OUT_W for a write; 2*(CMD_W+IN_W) for a read.
  - Shift edge: mosi advances to the next bit.
  - Sample edge: during the read phase, miso is shifted into an internal register, MSB first.
  - During the read phase mosi=0.
  - After the final edge, sclk=CPOL; go to DONE.
- DONE (1 clk):
  - end_of_transaction=1 and ss_n all 1.
  - If read: incoming_data is loaded with the captured byte in the same cycle. If write: incoming_data holds its value.
  - Next state IDLE.
- Back-to-back: if start_transaction is still high, the next transaction is accepted in the IDLE cycle after DONE. This gives a minimum 1 clk gap with ss_n high between transactions.
- Latency for CPHA=0:
  - Write: 1 (SETUP) + 32 + 1 = 34 clks from leaving IDLE to the end_of_transaction cycle.
  - Read: 34 as well (8 + 8 bits).
- Input timing:
  - Inputs other than reset are only sampled in IDLE; changes during a transaction have no effect.
  - Deasserting enable mid-transaction lets the transaction finish.
- Bit counter: must hold the maximum edge count, at least $clog2(2*max(OUT_W, CMD_W+IN_W))+1 bits.

Optional Feature:
- Macro QUICK_SPI_LSB_FIRST_EN.
- Defined: all shifting is LSB first.
  - Write sends outgoing_data[0] first.
  - Command uses outgoing_data[CMD_W-1:0], LSB first.
  - Received bits fill incoming_data from bit 0 upward.
- Undefined: MSB first as described above.

Decomposition:
- Shared package quick_spi_pkg: FSM state enum (IDLE, SETUP, SHIFT, DONE) and the operation encodings OP_WRITE=0, OP_READ=1.
- One natural sub-module quick_spi_sclk_gen: produces sclk, shift_strobe and sample_strobe from CPOL/CPHA and a run enable.
- The shift registers and FSM stay in the top.

Test Plan:
- Write to slave 1:
  - Stimulus: reset, then enable=1, start=1, slave=1, operation=0, outgoing_data=0x5A5A.
  - Required: ss_n=2'b01 throughout; mosi sampled on sclk rising edges = 0101101001011010; 16 sclk pulses; single end_of_transaction pulse; ss_n returns to 2'b11.
- Read from slave 1:
  - Stimulus: operation=1, outgoing_data=0x5A5A; slave updates miso on sclk falling edges, returning 0x95 after the 8 command bits.
  - Required: mosi = 01011010 then 0; incoming_data=0x95 in the end_of_transaction cycle.
- Alternating operations:
  - Stimulus: start held high; operation toggled on every end_of_transaction.
  - Required: write/read alternate; exactly 1 idle clk with ss_n=2'b11 between them; incoming_data unchanged across writes.
- enable=0 with start=1 for 20 clks:
  - Required: ss_n=2'b11, sclk=0, no end_of_transaction.
- Abort and out-of-range slave:
  - Stimulus: reset_n pulsed low at bit 7 of a write.
  - Required: all outputs return to reset values asynchronously; a new transaction starts cleanly after release.
  - Stimulus: slave=2 with start=1.
  - Required: the request is ignored.

Source files
------------

// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick SPI master: FSM state encoding and
// the operation select values.
package quick_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

endpackage

// File: rtl/quick_spi_sclk_gen.sv
// SPI clock generator: sclk toggles on every clk while run is high and
// reports which SPI edge (shift or sample) each toggle represents.
module quick_spi_sclk_gen #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic sclk,
  output logic shift_strobe,
  output logic sample_strobe
);

  logic sclk_q;
  logic sclk_d;
  logic leading;
  logic trailing;

  always_comb begin
    sclk_d = run ? ~sclk_q : CPOL;
  end

  // A toggle away from the idle level is the leading edge.
  assign leading  = run && (sclk_q == CPOL);
  assign trailing = run && (sclk_q != CPOL);

  assign shift_strobe  = CPHA ? leading : trailing;
  assign sample_strobe = CPHA ? trailing : leading;
  assign sclk          = sclk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= CPOL;
    end else begin
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/quick_spi_master.sv
// Byte-oriented SPI master: 16-bit writes, 8-bit command + 8-bit response reads.
// Define QUICK_SPI_LSB_FIRST_EN to shift all data LSB first instead of MSB first.
module quick_spi_master
  import quick_spi_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SLAVE_ID_W = 2,
  parameter int OUT_W      = 16,
  parameter int CMD_W      = 8,
  parameter int IN_W       = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  start_transaction,
  input  logic [SLAVE_ID_W-1:0] slave,
  input  logic                  operation,
  input  logic [OUT_W-1:0]      outgoing_data,
  input  logic                  miso,
  output logic                  end_of_transaction,
  output logic [IN_W-1:0]       incoming_data,
  output logic                  mosi,
  output logic                  sclk,
  output logic [NUM_SLAVES-1:0] ss_n
);

  localparam int MAX_BITS = (OUT_W > CMD_W + IN_W) ? OUT_W : CMD_W + IN_W;
  localparam int CNT_W    = $clog2(2 * MAX_BITS) + 1;

  state_e                state_q, state_d;
  logic                  op_q, op_d;
  logic [OUT_W-1:0]      tx_q, tx_d;
  logic [IN_W-1:0]       rx_q, rx_d;
  logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic                  mosi_q, mosi_d;
  logic [NUM_SLAVES-1:0] ss_n_q, ss_n_d;
  logic                  eot_q, eot_d;
  logic [IN_W-1:0]       incoming_q, incoming_d;

  logic             accept;
  logic             run;
  logic             shift_strobe;
  logic             sample_strobe;
  logic [CNT_W-1:0] total_edges;
  logic [OUT_W-1:0] word_ord;
  logic [CMD_W-1:0] cmd_ord;
  logic [OUT_W-1:0] tx_load;

  // word_ord/cmd_ord hold the outgoing bits in transmit order, first bit at the MSB.
`ifdef QUICK_SPI_LSB_FIRST_EN
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_rev_word
    assign word_ord[gi] = outgoing_data[OUT_W-1-gi];
  end
  for (genvar gi = 0; gi < CMD_W; gi++) begin : g_rev_cmd
    assign cmd_ord[gi] = outgoing_data[CMD_W-1-gi];
  end
`else
  assign word_ord = outgoing_data;
  assign cmd_ord  = outgoing_data[OUT_W-1 -: CMD_W];
`endif

  // Reads place the command at the top; zeros fill behind it so mosi idles low while reading.
  assign tx_load = (operation == OP_READ) ? (OUT_W'(cmd_ord) << (OUT_W - CMD_W)) : word_ord;

  assign accept = (state_q == IDLE) && enable && start_transaction &&
                  ({{(32-SLAVE_ID_W){1'b0}}, slave} < 32'(NUM_SLAVES));

  assign total_edges = (op_q == OP_READ) ? CNT_W'(2 * (CMD_W + IN_W)) : CNT_W'(2 * OUT_W);

  assign run = (state_d == SHIFT);

  quick_spi_sclk_gen #(
    .CPOL (CPOL),
    .CPHA (CPHA)
  ) u_sclk_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .sclk          (sclk),
    .shift_strobe  (shift_strobe),
    .sample_strobe (sample_strobe)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = SHIFT;
      SHIFT:   if (edge_cnt_q == total_edges) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    edge_cnt_d = edge_cnt_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    incoming_d = incoming_q;
    eot_d      = (state_d == DONE);

    if (accept) begin
      op_d       = operation;
      tx_d       = tx_load;
      edge_cnt_d = '0;
      ss_n_d     = ~(NUM_SLAVES'(1) << slave);
      if (!CPHA) mosi_d = tx_load[OUT_W-1];
    end

    if (run) edge_cnt_d = edge_cnt_q + CNT_W'(1);

    // With CPHA=0 the current bit is already on mosi, so the shift edge presents the next one.
    if (shift_strobe) begin
      mosi_d = CPHA ? tx_q[OUT_W-1] : tx_q[OUT_W-2];
      tx_d   = tx_q << 1;
    end

    if (sample_strobe && (op_q == OP_READ) && (edge_cnt_q >= CNT_W'(2 * CMD_W))) begin
`ifdef QUICK_SPI_LSB_FIRST_EN
      rx_d = {miso, rx_q[IN_W-1:1]};
`else
      rx_d = {rx_q[IN_W-2:0], miso};
`endif
    end

    if (state_d == DONE) begin
      ss_n_d = '1;
      if (op_q == OP_READ) incoming_d = rx_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_WRITE;
      tx_q       <= '0;
      rx_q       <= '0;
      edge_cnt_q <= '0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
      eot_q      <= 1'b0;
      incoming_q <= '0;
    end else begin
      op_q       <= op_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      edge_cnt_q <= edge_cnt_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      eot_q      <= eot_d;
      incoming_q <= incoming_d;
    end
  end

  assign mosi               = mosi_q;
  assign ss_n               = ss_n_q;
  assign end_of_transaction = eot_q;
  assign incoming_data      = incoming_q;

endmodule

// File: tb/tb_quick_spi_master.sv
// Directed bench for quick_spi_master (default build: CPOL=0, CPHA=0, MSB first).
module tb_quick_spi_master;
  import quick_spi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        start_transaction;
  logic [1:0]  slave;
  logic        operation;
  logic [15:0] outgoing_data;
  logic        miso;
  logic        end_of_transaction;
  logic [7:0]  incoming_data;
  logic        mosi;
  logic        sclk;
  logic [1:0]  ss_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  quick_spi_master dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .start_transaction  (start_transaction),
    .slave              (slave),
    .operation          (operation),
    .outgoing_data      (outgoing_data),
    .miso               (miso),
    .end_of_transaction (end_of_transaction),
    .incoming_data      (incoming_data),
    .mosi               (mosi),
    .sclk               (sclk),
    .ss_n               (ss_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one transaction clock by clock, acting as the slave (miso changes on sclk fall).
  task automatic run_txn(input string tag, input logic op, input logic [15:0] data,
                         input logic [1:0] sl, input logic [7:0] resp,
                         input logic [15:0] exp_bits, input logic [7:0] exp_in,
                         input logic keep_start, input logic chk_gap);
    logic [15:0] bits;
    logic [1:0]  exp_ss;
    logic        prev_sclk;
    logic        ss_ok;
    logic        done;
    int          rises, low_cyc, gap, waited, idx;
    bits      = '0;
    exp_ss    = ~(2'b01 << sl);
    prev_sclk = sclk;
    ss_ok     = 1'b1;
    done      = 1'b0;
    rises     = 0;
    low_cyc   = 0;
    gap       = 0;
    waited    = 0;
    operation         = op;
    outgoing_data     = data;
    slave             = sl;
    enable            = 1'b1;
    start_transaction = 1'b1;
    miso              = 1'b0;
    while (!done && waited < 80) begin
      @(negedge clk);
      waited++;
      if (!prev_sclk && sclk) begin
        bits = {bits[14:0], mosi};
        rises++;
      end
      if (prev_sclk && !sclk) begin
        idx  = 15 - rises;
        miso = (rises >= 8 && rises < 16) ? resp[idx[2:0]] : 1'b0;
      end
      prev_sclk = sclk;
      if (ss_n != 2'b11) begin
        low_cyc++;
        if (ss_n !== exp_ss) ss_ok = 1'b0;
      end else if (low_cyc == 0) begin
        gap++;
      end
      if (end_of_transaction) begin
        done = 1'b1;
        check({tag, " incoming_data"}, 32'(incoming_data), 32'(exp_in));
        check({tag, " ss_n at eot"}, 32'(ss_n), 32'h3);
      end
    end
    if (!keep_start) start_transaction = 1'b0;
    check({tag, " eot seen"}, 32'(done), 32'h1);
    check({tag, " mosi bits"}, 32'(bits), 32'(exp_bits));
    check({tag, " sclk pulses"}, 32'(rises), 32'd16);
    check({tag, " ss_n low clks"}, 32'(low_cyc), 32'd33);
    check({tag, " ss_n value"}, 32'(ss_ok), 32'h1);
    if (chk_gap) check({tag, " idle gap"}, 32'(gap), 32'd1);
    $display("[TB] txn %s op=%0d slave=%0d mosi=0x%04h incoming=0x%02h", tag, op, sl, bits, incoming_data);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int bad, eots;
    bad  = 0;
    eots = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ss_n !== 2'b11 || sclk !== 1'b0) bad++;
      if (end_of_transaction) eots++;
    end
    check({tag, " bus active clks"}, 32'(bad), 32'd0);
    check({tag, " eot pulses"}, 32'(eots), 32'd0);
    $display("[TB] txn %s ignored for %0d clks", tag, cycles);
  endtask

  initial begin
    reset_n           = 1'b0;
    enable            = 1'b0;
    start_transaction = 1'b0;
    slave             = 2'd0;
    operation         = OP_WRITE;
    outgoing_data     = 16'h0;
    miso              = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ss_n", 32'(ss_n), 32'h3);
    check("reset sclk", 32'(sclk), 32'h0);
    check("reset mosi", 32'(mosi), 32'h0);
    check("reset eot", 32'(end_of_transaction), 32'h0);
    check("reset incoming", 32'(incoming_data), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("write_s1", OP_WRITE, 16'h5A5A, 2'd1, 8'h00, 16'h5A5A, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("write_s1 single eot", 32'(end_of_transaction), 32'h0);
    check("write_s1 ss_n after", 32'(ss_n), 32'h3);
    repeat (2) @(negedge clk);

    run_txn("read_s1", OP_READ, 16'h5A5A, 2'd1, 8'h95, 16'h5A00, 8'h95, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back with start held high; operation flips at each completion.
    run_txn("alt_w0", OP_WRITE, 16'h1234, 2'd0, 8'h00, 16'h1234, 8'h95, 1'b1, 1'b0);
    run_txn("alt_r1", OP_READ,  16'hC3FF, 2'd1, 8'h3C, 16'hC300, 8'h3C, 1'b1, 1'b1);
    run_txn("alt_w2", OP_WRITE, 16'h8001, 2'd0, 8'h00, 16'h8001, 8'h3C, 1'b1, 1'b1);
    run_txn("alt_r3", OP_READ,  16'h0F00, 2'd0, 8'hA5, 16'h0F00, 8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    enable            = 1'b0;
    start_transaction = 1'b1;
    slave             = 2'd1;
    idle_watch("enable_off", 20);

    enable = 1'b1;
    slave  = 2'd2;
    idle_watch("slave_2", 20);
    slave  = 2'd3;
    idle_watch("slave_3", 10);
    start_transaction = 1'b0;
    @(negedge clk);

    // Abort a write of all ones partway through (around bit 7).
    operation         = OP_WRITE;
    outgoing_data     = 16'hFFFF;
    slave             = 2'd1;
    start_transaction = 1'b1;
    repeat (15) @(negedge clk);
    check("abort in progress ss_n", 32'(ss_n), 32'h1);
    check("abort in progress mosi", 32'(mosi), 32'h1);
    start_transaction = 1'b0;
    reset_n           = 1'b0;
    #1;
    check("abort ss_n", 32'(ss_n), 32'h3);
    check("abort sclk", 32'(sclk), 32'h0);
    check("abort mosi", 32'(mosi), 32'h0);
    check("abort eot", 32'(end_of_transaction), 32'h0);
    check("abort incoming", 32'(incoming_data), 32'h0);
    $display("[TB] txn abort reset applied mid-write");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_txn("post_abort_w0", OP_WRITE, 16'hA5C3, 2'd0, 8'h00, 16'hA5C3, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
